matrix_line_scanner: RTL and testbench

Parametrised scan engine for the SPI-driven LED matrix. It takes pixel words over a valid/ready stream and shifts them out simultaneously on ROW_NUMBER MOSI lanes with a shared, divided spi_clk. After each full line it advances the row-select 74HC595-style shift-register chain, with blanking around the update. It sits between the frame buffer/HDMI capture path and the board pins, and replaces the fixed-pin top-level drive with a reusable block.

---
 rtl/matrix_pkg.sv | 26 ++
 rtl/matrix_line_scanner_if.sv | 21 ++
 rtl/half_period_timer.sv | 42 ++++
 rtl/matrix_line_scanner.sv | 200 ++++++++++++++++++++
 tb/tb_matrix_line_scanner.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg
// Shared definitions for the LED-matrix line scanner:
//   scan_state_t    - scan FSM state encoding
//   DEF_*           - default geometry used by the scanner and its stream interface
//   lane_lsb()      - bit offset of a lane slice inside the packed multi-lane word
package matrix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SEL_SETUP,
    ST_SEL_CLK,
    ST_SEL_LATCH
  } scan_state_t;

  localparam int DEF_ROW_NUMBER = 3;
  localparam int DEF_WORD_W     = 8;
  localparam int DEF_SEL_DEPTH  = 8;

  // Lane k occupies bits [k*word_w +: word_w] of the packed pixel word.
  function automatic int lane_lsb(input int lane, input int word_w);
    return lane * word_w;
  endfunction

endpackage

// File: rtl/matrix_line_scanner_if.sv
// matrix_line_scanner_if
// Valid/ready pixel-word stream feeding the line scanner.
//   s_valid : upstream has a word
//   s_ready : scanner accepts the word this cycle
//   s_data  : ROW_NUMBER lanes of WORD_W bits, lane k at [k*WORD_W +: WORD_W]
// Modports: master = upstream source, slave = scanner.
interface matrix_line_scanner_if
  import matrix_pkg::*;
#(
  parameter int ROW_NUMBER = DEF_ROW_NUMBER,
  parameter int WORD_W     = DEF_WORD_W
) ();

  logic                         s_valid;
  logic                         s_ready;
  logic [ROW_NUMBER*WORD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/half_period_timer.sv
// half_period_timer
// Counts CLK_DIV clk cycles per half-period of the generated serial clocks.
//   clk, rst : system clock, synchronous active-high reset
//   run_i    : count while high
//   clear_i  : force the count back to zero (aligns the first half-period)
//   tick_o   : high on the last cycle of each half-period while running
module half_period_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !run_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matrix_line_scanner.sv
// matrix_line_scanner
// Shifts pixel words out on ROW_NUMBER parallel MOSI lanes with a shared
// divided spi_clk, and after every WORDS_PER_LINE words advances the
// 74HC595-style row-select chain with blanking around the update.
//   clk, rst    : system clock, synchronous active-high reset
//   enable      : run scanning (acted on only in IDLE/LOAD)
//   s_if        : pixel-word valid/ready stream (slave)
//   spi_clk     : serial clock, idle low; slaves sample on its rising edge
//   spi_mosi    : one serial data line per lane, MSB first
//   shift_clk   : select-chain shift clock, idle low
//   shift_ser   : select-chain serial input
//   shift_stcp  : select-chain storage latch, idle low
//   shift_en    : select-chain output enable, active-low
//   line_idx    : currently enabled line
//   busy        : high in any state except IDLE
module matrix_line_scanner
  import matrix_pkg::*;
#(
  parameter int ROW_NUMBER     = DEF_ROW_NUMBER,
  parameter int WORD_W         = DEF_WORD_W,
  parameter int WORDS_PER_LINE = 48,
  parameter int SEL_DEPTH      = DEF_SEL_DEPTH,
  parameter int CLK_DIV        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  matrix_line_scanner_if.slave         s_if,
  output logic                         spi_clk,
  output logic [ROW_NUMBER-1:0]        spi_mosi,
  output logic                         shift_clk,
  output logic                         shift_ser,
  output logic                         shift_stcp,
  output logic                         shift_en,
  output logic [$clog2(SEL_DEPTH)-1:0] line_idx,
  output logic                         busy
);

  localparam int BUS_W  = ROW_NUMBER * WORD_W;
  localparam int LINE_W = $clog2(SEL_DEPTH);
  localparam int BCNT_W = $clog2(WORD_W);
  localparam int WCNT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  scan_state_t       state_q, state_d;
  logic [BUS_W-1:0]  shreg_q, shreg_d, shreg_shift;
  logic [BCNT_W-1:0] bit_q, bit_d;
  logic [WCNT_W-1:0] word_q, word_d;
  logic [LINE_W-1:0] line_q, line_d, line_next;
  logic              spi_clk_q, spi_clk_d;
  logic              shift_clk_q, shift_clk_d;
  logic              shift_ser_q, shift_ser_d;
  logic              stcp_q, stcp_d;
  logic              shift_en_q, shift_en_d;

  logic s_ready_w, handshake, tick, timed, last_bit, line_full;

  // Per-lane MSB taps and one-bit left shift of every lane slice.
  for (genvar gi = 0; gi < ROW_NUMBER; gi++) begin : g_lane
    localparam int LSB = lane_lsb(gi, WORD_W);
    assign shreg_shift[LSB +: WORD_W] = {shreg_q[LSB +: WORD_W-1], 1'b0};
    assign spi_mosi[gi]               = shreg_q[LSB + WORD_W - 1];
  end

  // The timer only runs in the clocked states; everywhere else it is held at
  // zero so each SHIFT / SEL_CLK starts with a full half-period.
  assign timed = (state_q == ST_SHIFT) || (state_q == ST_SEL_CLK) ||
                 (state_q == ST_SEL_LATCH);

  half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run_i   (timed),
    .clear_i (!timed),
    .tick_o  (tick)
  );

  assign handshake = s_if.s_valid && s_ready_w;
  assign last_bit  = (bit_q == BCNT_W'(WORD_W - 1));
  assign line_full = (word_q == WCNT_W'(WORDS_PER_LINE - 1));
  assign line_next = (line_q == LINE_W'(SEL_DEPTH - 1)) ? '0 : line_q + 1'b1;

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      line_q      <= '0;
      spi_clk_q   <= 1'b0;
      shift_clk_q <= 1'b0;
      shift_ser_q <= 1'b0;
      stcp_q      <= 1'b0;
      shift_en_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      line_q      <= line_d;
      spi_clk_q   <= spi_clk_d;
      shift_clk_q <= shift_clk_d;
      shift_ser_q <= shift_ser_d;
      stcp_q      <= stcp_d;
      shift_en_q  <= shift_en_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!enable)        state_d = ST_IDLE;
        else if (handshake) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Word ends on the falling-edge tick of the last bit.
        if (tick && spi_clk_q && last_bit) state_d = line_full ? ST_SEL_SETUP : ST_LOAD;
      end
      ST_SEL_SETUP: state_d = ST_SEL_CLK;
      ST_SEL_CLK:   if (tick && !shift_clk_q) state_d = ST_SEL_LATCH;
      ST_SEL_LATCH: if (tick && !stcp_q) state_d = ST_LOAD;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-value logic.
  always_comb begin
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    word_d      = word_q;
    line_d      = line_q;
    spi_clk_d   = spi_clk_q;
    shift_clk_d = shift_clk_q;
    shift_ser_d = shift_ser_q;
    stcp_d      = stcp_q;
    shift_en_d  = shift_en_q;
    s_ready_w   = (state_q == ST_LOAD) && enable;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_LOAD: begin
        if (handshake) begin
          shreg_d   = s_if.s_data;
          bit_d     = '0;
          spi_clk_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!spi_clk_q) begin
            spi_clk_d = 1'b1;
          end else begin
            spi_clk_d = 1'b0;
            if (last_bit) begin
              // MOSI holds the last bit; only the word count moves on.
              word_d = line_full ? '0 : word_q + 1'b1;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = shreg_shift;
            end
          end
        end
      end
      ST_SEL_SETUP: begin
        // A single 1 walks down the chain; inject it when wrapping to line 0.
        shift_en_d  = 1'b1;
        shift_ser_d = (line_next == '0);
        shift_clk_d = 1'b1;
      end
      ST_SEL_CLK: begin
        if (tick) begin
          if (shift_clk_q) shift_clk_d = 1'b0;
          else             stcp_d      = 1'b1;
        end
      end
      ST_SEL_LATCH: begin
        if (tick) begin
          if (stcp_q) begin
            stcp_d = 1'b0;
          end else begin
            line_d     = line_next;
            shift_en_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign s_if.s_ready = s_ready_w;
  assign spi_clk      = spi_clk_q;
  assign shift_clk    = shift_clk_q;
  assign shift_ser    = shift_ser_q;
  assign shift_stcp   = stcp_q;
  assign shift_en     = shift_en_q;
  assign line_idx     = line_q;

endmodule

// File: tb/tb_matrix_line_scanner.sv
// tb_matrix_line_scanner
// Scoreboard bench: every accepted word pushes its expected per-edge lane bits;
// a negedge monitor pops and compares on each rising spi_clk.
module tb_matrix_line_scanner;

  localparam int RN  = 3;
  localparam int WW  = 8;
  localparam int WPL = 2;
  localparam int SD  = 4;
  localparam int CD  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          spi_clk;
  logic [RN-1:0] spi_mosi;
  logic          shift_clk, shift_ser, shift_stcp, shift_en;
  logic [1:0]    line_idx;
  logic          busy;

  matrix_line_scanner_if #(.ROW_NUMBER(RN), .WORD_W(WW)) s_if ();

  matrix_line_scanner #(
    .ROW_NUMBER(RN), .WORD_W(WW), .WORDS_PER_LINE(WPL), .SEL_DEPTH(SD), .CLK_DIV(CD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .s_if       (s_if.slave),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .shift_clk  (shift_clk),
    .shift_ser  (shift_ser),
    .shift_stcp (shift_stcp),
    .shift_en   (shift_en),
    .line_idx   (line_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [RN-1:0] exp_q[$];
  int   spi_edges = 0;
  int   sclk_edges = 0;
  int   stcp_edges = 0;
  logic ser_at_rise = 1'b0;
  logic en_at_rise = 1'b0;
  logic spi_prev = 1'b0, sclk_prev = 1'b0, stcp_prev = 1'b0;

  // Monitor: sampled on the inactive edge.
  always @(negedge clk) begin
    logic [RN-1:0] e;
    if (spi_clk === 1'b1 && spi_prev === 1'b0) begin
      spi_edges++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL spi_edge_unexpected: mosi=%b, no edge was expected", spi_mosi);
      end else begin
        e = exp_q.pop_front();
        if (spi_mosi !== e) begin
          tests_failed++;
          $display("FAIL mosi_bit: got %b expected %b", spi_mosi, e);
        end else begin
          $display("[TB] spi edge %0d mosi=%b ok", spi_edges, spi_mosi);
        end
      end
    end
    if (shift_clk === 1'b1 && sclk_prev === 1'b0) begin
      sclk_edges++;
      ser_at_rise = shift_ser;
      en_at_rise  = shift_en;
    end
    if (shift_stcp === 1'b1 && stcp_prev === 1'b0) stcp_edges++;
    spi_prev  = spi_clk;
    sclk_prev = shift_clk;
    stcp_prev = shift_stcp;
  end

  task automatic send_word(input logic [RN*WW-1:0] d);
    bit ok;
    logic [RN-1:0] e;
    ok = 1'b0;
    @(negedge clk);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    for (int budget = 0; budget < 200; budget++) begin
      if (s_if.s_ready === 1'b1) begin
        for (int b = WW - 1; b >= 0; b--) begin
          for (int k = 0; k < RN; k++) e[k] = d[k*WW + b];
          exp_q.push_back(e);
        end
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    s_if.s_valid = 1'b0;
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: s_ready=%b, required 1 within 200 cycles", s_if.s_ready);
    end else begin
      $display("[TB] word %h accepted", d);
    end
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (s_if.s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wait_ready_timeout: s_ready=%b, required 1", s_if.s_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({spi_clk, spi_mosi, shift_clk, shift_ser, shift_stcp} !== '0) begin
      tests_failed++;
      $display("FAIL reset_pins: got spi_clk=%b mosi=%b shift_clk=%b ser=%b stcp=%b, required all 0",
               spi_clk, spi_mosi, shift_clk, shift_ser, shift_stcp);
    end
    tests_run++;
    if (shift_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_shift_en: got %b required 1", shift_en);
    end
    tests_run++;
    if (line_idx !== 2'd0 || busy !== 1'b0 || s_if.s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: got line_idx=%0d busy=%b s_ready=%b, required 0/0/0",
               line_idx, busy, s_if.s_ready);
    end
    $display("[TB] reset checked");
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int e0;
    bit ready_seen;
    ready_seen = 1'b0;
    enable = 1'b1;
    e0 = spi_edges;
    send_word(24'hA5_3C_F0);
    // Now in the first SHIFT cycle; the word takes 16 cycles in total.
    for (int i = 0; i < 16; i++) begin
      if (s_if.s_ready !== 1'b0 || busy !== 1'b1) ready_seen = 1'b1;
      if (i < 15) @(negedge clk);
    end
    tests_run++;
    if (ready_seen) begin
      tests_failed++;
      $display("FAIL word_s_ready_low: s_ready rose or busy fell during the 16 shift cycles, required s_ready=0 busy=1");
    end
    @(negedge clk);
    tests_run++;
    if (s_if.s_ready !== 1'b1 || spi_clk !== 1'b0) begin
      tests_failed++;
      $display("FAIL word_length: after 16 cycles s_ready=%b spi_clk=%b, required 1/0", s_if.s_ready, spi_clk);
    end
    tests_run++;
    if (spi_edges - e0 != 8) begin
      tests_failed++;
      $display("FAIL word_edges: got %0d rising edges, required 8", spi_edges - e0);
    end
    tests_run++;
    if (spi_mosi !== 3'b100) begin
      tests_failed++;
      $display("FAIL mosi_hold: got %b, required 100", spi_mosi);
    end
    $display("[TB] single word done, edges=%0d", spi_edges - e0);
  endtask

  task automatic test_line_select();
    int sc0, st0;
    sc0 = sclk_edges;
    st0 = stcp_edges;
    send_word(24'h12_34_56);
    wait_ready();
    tests_run++;
    if (sclk_edges - sc0 != 1 || stcp_edges - st0 != 1) begin
      tests_failed++;
      $display("FAIL sel_pulses: got shift_clk=%0d stcp=%0d pulses, required 1/1",
               sclk_edges - sc0, stcp_edges - st0);
    end
    tests_run++;
    if (ser_at_rise !== 1'b0 || en_at_rise !== 1'b1) begin
      tests_failed++;
      $display("FAIL sel_setup: got ser=%b en=%b at shift_clk rise, required 0/1", ser_at_rise, en_at_rise);
    end
    tests_run++;
    if (shift_en !== 1'b0 || line_idx !== 2'd1) begin
      tests_failed++;
      $display("FAIL sel_result: got shift_en=%b line_idx=%0d, required 0/1", shift_en, line_idx);
    end
    $display("[TB] select update line_idx=%0d", line_idx);
  endtask

  task automatic test_underflow();
    int e0;
    bit bad;
    bad = 1'b0;
    e0 = spi_edges;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (spi_clk !== 1'b0 || s_if.s_ready !== 1'b1) bad = 1'b1;
    end
    tests_run++;
    if (bad || spi_edges != e0) begin
      tests_failed++;
      $display("FAIL underflow: spi_clk=%b s_ready=%b edges=%0d, required 0/1/0",
               spi_clk, s_if.s_ready, spi_edges - e0);
    end
    $display("[TB] underflow 10 cycles checked");
  endtask

  task automatic test_enable_drop();
    int e0;
    bit idle_ok;
    idle_ok = 1'b0;
    e0 = spi_edges;
    send_word(24'hC3_81_7E);
    for (int i = 0; i < 100; i++) begin
      if (spi_edges - e0 >= 3) break;
      @(negedge clk);
    end
    enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        idle_ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!idle_ok) begin
      tests_failed++;
      $display("FAIL drop_idle_timeout: busy=%b, required 0", busy);
    end
    tests_run++;
    if (spi_edges - e0 != 8) begin
      tests_failed++;
      $display("FAIL drop_edges: got %0d edges, required 8", spi_edges - e0);
    end
    tests_run++;
    if (s_if.s_ready !== 1'b0 || spi_clk !== 1'b0 || shift_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_state: s_ready=%b spi_clk=%b shift_en=%b, required 0/0/0",
               s_if.s_ready, spi_clk, shift_en);
    end
    $display("[TB] enable drop finished word, edges=%0d", spi_edges - e0);
  endtask

  task automatic test_reset_mid_sel();
    bit hit;
    hit = 1'b0;
    enable = 1'b1;
    send_word(24'h0F_F0_AA);
    for (int i = 0; i < 100; i++) begin
      if (shift_clk === 1'b1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!hit || line_idx !== 2'd1) begin
      tests_failed++;
      $display("FAIL sel_clk_reach: shift_clk=%b line_idx=%0d, required 1/1", shift_clk, line_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (shift_clk !== 1'b0 || shift_en !== 1'b1 || line_idx !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_sel: shift_clk=%b shift_en=%b line_idx=%0d, required 0/1/0",
               shift_clk, shift_en, line_idx);
    end
    tests_run++;
    if (busy !== 1'b0 || s_if.s_ready !== 1'b0 || shift_stcp !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_idle: busy=%b s_ready=%b stcp=%b, required 0/0/0",
               busy, s_if.s_ready, shift_stcp);
    end
    $display("[TB] reset during select update checked");
    rst = 1'b0;
  endtask

  task automatic test_line_wrap();
    int sc0, st0;
    logic [1:0] exp_line;
    logic exp_ser;
    for (int p = 0; p < SD; p++) begin
      sc0 = sclk_edges;
      st0 = stcp_edges;
      send_word(24'($urandom));
      send_word(24'($urandom));
      wait_ready();
      exp_line = 2'((p + 1) % SD);
      exp_ser  = (p == SD - 1);
      tests_run++;
      if (line_idx !== exp_line || shift_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL wrap_line: got line_idx=%0d shift_en=%b, required %0d/0", line_idx, shift_en, exp_line);
      end
      tests_run++;
      if (ser_at_rise !== exp_ser || sclk_edges - sc0 != 1 || stcp_edges - st0 != 1) begin
        tests_failed++;
        $display("FAIL wrap_sel: got ser=%b shift_clk=%0d stcp=%0d, required %b/1/1",
                 ser_at_rise, sclk_edges - sc0, stcp_edges - st0, exp_ser);
      end
      $display("[TB] line update %0d line_idx=%0d ser=%b", p, line_idx, ser_at_rise);
    end
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    test_reset();
    test_single_word();
    test_line_select();
    test_underflow();
    test_enable_drop();
    test_reset_mid_sel();
    test_line_wrap();
    repeat (4) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d bits left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
